jtag_scan_master: RTL and testbench
===================================

Name: jtag_scan_master

Overview:
- Host-side JTAG initiator. It drives TMS/TDI into a TAP (TAP controller plus instruction and data registers) and collects TDO.
- Accepts one scan command at a time (IR scan or DR scan of N bits).
- Walks the TAP from Run-Test/Idle through Capture, Shift, Exit1 and Update, then back to Run-Test/Idle.
- Returns the captured TDO bits. Used by the debug/test controller to program IR and read or write DRs.

Parameters:
- IR_LENGTH, 5: instruction register length in bits; IR scans always shift exactly this many bits.
- DR_MAX, 32: maximum DR scan length; width of cmd_data and rsp_data.
- LEN_W, $clog2(DR_MAX+1): width of cmd_len.

Ports:
- TCK  input  1  scan clock; all state changes on posedge.
- TRST_N  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  high when idle and able to accept a command.
- cmd_is_ir  input  1  1 = IR scan, 0 = DR scan.
- cmd_len  input  LEN_W  DR scan length; ignored for IR scans.
- cmd_data  input  DR_MAX  bits to shift, right-aligned; bit len-1 is sent first.
- TMS  output  1  TAP mode select, registered.
- TDI  output  1  TAP serial data in, registered.
- TDO  input  1  TAP serial data out.
- rsp_valid  output  1  one-cycle pulse when a scan completes.
- rsp_data  output  DR_MAX  captured TDO bits, right-aligned; bit len-1 is the first bit captured; upper bits are 0.

Behaviour:
- Reset values (TRST_N low, asynchronous): TMS=1, TDI=0, cmd_ready=0, rsp_valid=0, rsp_data=0, state=RESET.
- Leaving reset: go to IDLE, with cmd_ready=1 and TMS=0, holding the TAP in Run-Test/Idle.
- States: RESET, IDLE, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE.
- Command acceptance:
  - A command is accepted on a posedge with cmd_valid && cmd_ready.
  - cmd_ready drops on that edge.
  - cmd_data and the effective length are latched.
- Effective length n:
  - IR scan: n = IR_LENGTH.
  - DR scan: n = min(cmd_len, DR_MAX).
- TMS sequence, one value per TCK, the first launched on the accept edge:
  - IR scan: 1,1,0,0, then n shift bits, then 1,0.
  - DR scan: 1,0,0, then n shift bits, then 1,0.
  - During the shift bits, TMS=0 for bits 0..n-2 and TMS=1 on bit n-1, moving the TAP to Exit1.
- TDI: bit k of the shift (k = 0..n-1) carries cmd_data[n-1-k], launched in the same cycle as the matching TMS. TDI=0 outside SHIFT.
- TDO capture:
  - TDO is sampled on each of the n edges at which the TAP consumes a TDI bit.
  - rsp_data is built as {rsp_data, TDO}.
- Latency:
  - IR scan: n+6 cycles from the accept edge to the rsp_valid edge.
  - DR scan: n+5 cycles.
- Completion:
  - rsp_valid pulses for one cycle, launched together with the final TMS=0 (Update to Run-Test/Idle).
  - rsp_data is stable from that edge until the next accept.
  - cmd_ready rises on the same edge, so back-to-back commands have no idle bubble.
- DR scan with cmd_len=0:
  - No TMS activity; TMS stays 0.
  - rsp_valid=1 and rsp_data=0 on the edge after accept.
- cmd_len > DR_MAX: clamped to DR_MAX; no error reported.
- cmd_valid while busy: ignored; cmd_ready=0 until completion.
- TRST_N asserted mid-scan:
  - Immediate abort; outputs return to their reset values.
  - No rsp_valid for the aborted command.
  - The TAP is returned to a known state by TMS=1, or by the optional sequence below.

Optional Feature:
- Macro: JTAG_RESET_SEQ_EN.
- Defined: after reset release, stay in RESET, drive TMS=1 for 5 TCK cycles, then TMS=0 for 1 cycle, then go to IDLE. cmd_ready rises on the 7th edge after release. This guarantees Test-Logic-Reset and then Run-Test/Idle without relying on the target's reset.
- Undefined: RESET exits to IDLE on the first edge after release. The target TAP is required to share TRST_N.

Decomposition:
- Shared package jtag_pkg holds:
  - TAP state enum with all 16 IEEE 1149.1 states.
  - Master state enum.
  - IR_LENGTH default (5).
  - BYPASS opcode (all ones).
- No sub-module. The bit counter (LEN_W wide) and shift register are inline.

Test Plan:
- IR scan of 5'b00010 into the TAP plus IR model -> IR_OUT=5'b00010 after Update; rsp_data[4:0]=5'b11111 (capture value); rsp_valid exactly 11 cycles after accept.
- DR scan, len=8, data 8'hA5, through an 8-bit target DR preloaded with 8'h3C -> target holds 8'hA5; rsp_data=32'h0000003C; rsp_valid 13 cycles after accept.
- Two back-to-back commands (IR 5'b11111, then DR len=1 data 1) -> second accept on the same edge as the first rsp_valid; TMS trace is 1,1,0,0,0,0,0,0,1,1,0 then 1,0,0,1,1,0.
- DR scan with cmd_len=0, then cmd_len=40 -> first completes in 1 cycle with rsp_data=0; second shifts 32 bits.
- TRST_N pulsed low during the 3rd shift bit -> TMS=1 and cmd_ready=0 immediately; no rsp_valid; a new scan after release succeeds.
- With JTAG_RESET_SEQ_EN -> TMS=1,1,1,1,1,0 after release; cmd_ready=1 on the 7th edge. Without the macro -> cmd_ready=1 on the 1st edge.

Source files
------------

// File: rtl/jtag_pkg.sv
`default_nettype none
// ============================================================================
// jtag_pkg : TAP and scan-master state encodings plus shared JTAG constants.
// Revision : 1.0
// ============================================================================
package jtag_pkg;

  localparam int c_IR_LENGTH = 5;
  localparam logic [c_IR_LENGTH-1:0] c_BYPASS = '1;

  // IEEE 1149.1 TAP controller states
  typedef enum logic [3:0] {
    TAP_TLR,
    TAP_RTI,
    TAP_SEL_DR,
    TAP_CAP_DR,
    TAP_SHIFT_DR,
    TAP_EXIT1_DR,
    TAP_PAUSE_DR,
    TAP_EXIT2_DR,
    TAP_UPD_DR,
    TAP_SEL_IR,
    TAP_CAP_IR,
    TAP_SHIFT_IR,
    TAP_EXIT1_IR,
    TAP_PAUSE_IR,
    TAP_EXIT2_IR,
    TAP_UPD_IR
  } tap_state_t;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_IDLE,
    ST_SEL_DR,
    ST_SEL_IR,
    ST_CAPTURE,
    ST_SHIFT,
    ST_EXIT1,
    ST_UPDATE
  } mst_state_t;

endpackage
`default_nettype wire

// File: rtl/jtag_scan_master.sv
`default_nettype none
// ============================================================================
// jtag_scan_master : host-side JTAG initiator, one IR or DR scan at a time.
// Option JTAG_RESET_SEQ_EN : drive TMS=1 x5 then TMS=0 after reset release.
// Revision : 1.0
// ============================================================================
module jtag_scan_master
  import jtag_pkg::*;
#(
  parameter int IR_LENGTH = c_IR_LENGTH,
  parameter int DR_MAX    = 32,
  parameter int LEN_W     = $clog2(DR_MAX + 1)
) (
  input  logic              TCK,
  input  logic              TRST_N,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_is_ir,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DR_MAX-1:0] cmd_data,
  output logic              TMS,
  output logic              TDI,
  input  logic              TDO,
  output logic              rsp_valid,
  output logic [DR_MAX-1:0] rsp_data
);

  localparam logic [LEN_W-1:0] c_DR_MAX_L = LEN_W'(DR_MAX);
  localparam logic [LEN_W-1:0] c_IR_LEN_L = LEN_W'(IR_LENGTH);
  localparam logic [LEN_W-1:0] c_ONE_L    = LEN_W'(1);

  mst_state_t        r_state, w_state;
  logic              r_tms, w_tms;
  logic              r_tdi, w_tdi;
  logic              r_ready, w_ready;
  logic              r_rsp_vld, w_rsp_vld;
  logic [DR_MAX-1:0] r_rsp, w_rsp;
  logic [DR_MAX-1:0] r_sh, w_sh;
  logic [LEN_W-1:0]  r_len, w_len;
  logic [LEN_W-1:0]  r_cnt, w_cnt;
  logic              r_is_ir, w_is_ir;
`ifdef JTAG_RESET_SEQ_EN
  logic [2:0]        r_rst_cnt, w_rst_cnt;
`endif

  logic [LEN_W-1:0]  w_eff_len;
  logic [LEN_W-1:0]  w_align;
  logic              w_accept;

  assign w_eff_len = cmd_is_ir ? c_IR_LEN_L :
                     ((cmd_len > c_DR_MAX_L) ? c_DR_MAX_L : cmd_len);
  assign w_align   = c_DR_MAX_L - w_eff_len;
  assign w_accept  = cmd_valid && r_ready;

  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      r_state <= ST_RESET;
    end else begin
      r_state <= w_state;
    end
  end

  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      r_tms     <= 1'b1;
      r_tdi     <= 1'b0;
      r_ready   <= 1'b0;
      r_rsp_vld <= 1'b0;
      r_rsp     <= '0;
      r_sh      <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_is_ir   <= 1'b0;
`ifdef JTAG_RESET_SEQ_EN
      r_rst_cnt <= '0;
`endif
    end else begin
      r_tms     <= w_tms;
      r_tdi     <= w_tdi;
      r_ready   <= w_ready;
      r_rsp_vld <= w_rsp_vld;
      r_rsp     <= w_rsp;
      r_sh      <= w_sh;
      r_len     <= w_len;
      r_cnt     <= w_cnt;
      r_is_ir   <= w_is_ir;
`ifdef JTAG_RESET_SEQ_EN
      r_rst_cnt <= w_rst_cnt;
`endif
    end
  end

  // Each state decides the TMS/TDI launched on the coming edge; the TAP
  // therefore runs one TCK behind the master state.
  always_comb begin
    w_state   = r_state;
    w_tms     = r_tms;
    w_tdi     = 1'b0;
    w_ready   = r_ready;
    w_rsp_vld = 1'b0;
    w_rsp     = r_rsp;
    w_sh      = r_sh;
    w_len     = r_len;
    w_cnt     = r_cnt;
    w_is_ir   = r_is_ir;
`ifdef JTAG_RESET_SEQ_EN
    w_rst_cnt = r_rst_cnt;
`endif
    case (r_state)
      ST_RESET: begin
`ifdef JTAG_RESET_SEQ_EN
        if (r_rst_cnt == 3'd6) begin
          w_state   = ST_IDLE;
          w_tms     = 1'b0;
          w_ready   = 1'b1;
          w_rst_cnt = '0;
        end else begin
          w_tms     = (r_rst_cnt != 3'd5);
          w_rst_cnt = r_rst_cnt + 3'd1;
        end
`else
        w_state = ST_IDLE;
        w_tms   = 1'b0;
        w_ready = 1'b1;
`endif
      end
      ST_IDLE: begin
        w_tms = 1'b0;
        if (w_accept) begin
          w_rsp   = '0;
          w_is_ir = cmd_is_ir;
          w_len   = w_eff_len;
          w_cnt   = '0;
          w_sh    = cmd_data << w_align;
          if (w_eff_len == '0) begin
            w_rsp_vld = 1'b1;
          end else begin
            w_tms   = 1'b1;
            w_ready = 1'b0;
            w_state = ST_SEL_DR;
          end
        end
      end
      ST_SEL_DR: begin
        w_tms   = r_is_ir;
        w_state = r_is_ir ? ST_SEL_IR : ST_CAPTURE;
      end
      ST_SEL_IR: begin
        w_tms   = 1'b0;
        w_state = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        w_tms   = 1'b0;
        w_state = ST_SHIFT;
      end
      ST_SHIFT: begin
        w_tdi = r_sh[DR_MAX-1];
        w_sh  = {r_sh[DR_MAX-2:0], 1'b0};
        w_cnt = r_cnt + c_ONE_L;
        // TDO for bit k is consumed together with TDI bit k, one edge later
        if (r_cnt != '0) begin
          w_rsp = {r_rsp[DR_MAX-2:0], TDO};
        end
        if (r_cnt == (r_len - c_ONE_L)) begin
          w_tms   = 1'b1;
          w_state = ST_EXIT1;
        end else begin
          w_tms = 1'b0;
        end
      end
      ST_EXIT1: begin
        w_rsp   = {r_rsp[DR_MAX-2:0], TDO};
        w_tms   = 1'b1;
        w_state = ST_UPDATE;
      end
      ST_UPDATE: begin
        w_tms     = 1'b0;
        w_rsp_vld = 1'b1;
        w_ready   = 1'b1;
        w_state   = ST_IDLE;
      end
      default: begin
        w_state = ST_RESET;
        w_tms   = 1'b1;
        w_ready = 1'b0;
      end
    endcase
  end

  assign TMS       = r_tms;
  assign TDI       = r_tdi;
  assign cmd_ready = r_ready;
  assign rsp_valid = r_rsp_vld;
  assign rsp_data  = r_rsp;

endmodule
`default_nettype wire

// File: tb/tb_jtag_scan_master.sv
`default_nettype none
// ============================================================================
// tb_jtag_scan_master : directed bench with a behavioural TAP, 5-bit IR and
// 8-bit DR target. Revision : 1.0
// ============================================================================
module tb_jtag_scan_master;
  import jtag_pkg::*;

  logic        TCK;
  logic        TRST_N;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_is_ir;
  logic [5:0]  cmd_len;
  logic [31:0] cmd_data;
  logic        TMS;
  logic        TDI;
  logic        TDO;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef JTAG_RESET_SEQ_EN
  localparam int          c_RDY_EDGE = 7;
  localparam logic [63:0] c_RST_TMS  = 64'b1111100;
`else
  localparam int          c_RDY_EDGE = 1;
  localparam logic [63:0] c_RST_TMS  = 64'b0;
`endif

  jtag_scan_master dut (
    .TCK       (TCK),
    .TRST_N    (TRST_N),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_is_ir (cmd_is_ir),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .TMS       (TMS),
    .TDI       (TDI),
    .TDO       (TDO),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data)
  );

  initial TCK = 1'b0;
  always #5 TCK = ~TCK;

  // ---------------- target TAP model (MSB-first shift registers) ----------
  tap_state_t tap_st;
  logic [4:0] ir_sh, ir_out;
  logic [7:0] dr_sh, dr;

  function automatic tap_state_t tap_next(input tap_state_t s, input logic m);
    case (s)
      TAP_TLR:      return m ? TAP_TLR      : TAP_RTI;
      TAP_RTI:      return m ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_DR:   return m ? TAP_SEL_IR   : TAP_CAP_DR;
      TAP_CAP_DR:   return m ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_SHIFT_DR: return m ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_EXIT1_DR: return m ? TAP_UPD_DR   : TAP_PAUSE_DR;
      TAP_PAUSE_DR: return m ? TAP_EXIT2_DR : TAP_PAUSE_DR;
      TAP_EXIT2_DR: return m ? TAP_UPD_DR   : TAP_SHIFT_DR;
      TAP_UPD_DR:   return m ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_IR:   return m ? TAP_TLR      : TAP_CAP_IR;
      TAP_CAP_IR:   return m ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_SHIFT_IR: return m ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_EXIT1_IR: return m ? TAP_UPD_IR   : TAP_PAUSE_IR;
      TAP_PAUSE_IR: return m ? TAP_EXIT2_IR : TAP_PAUSE_IR;
      TAP_EXIT2_IR: return m ? TAP_UPD_IR   : TAP_SHIFT_IR;
      default:      return m ? TAP_SEL_DR   : TAP_RTI;
    endcase
  endfunction

  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      tap_st <= TAP_TLR;
      ir_sh  <= '0;
      ir_out <= 5'b00001;
      dr_sh  <= '0;
      dr     <= 8'h3C;
    end else begin
      tap_st <= tap_next(tap_st, TMS);
      case (tap_st)
        TAP_CAP_IR:   ir_sh  <= 5'b11111;
        TAP_SHIFT_IR: ir_sh  <= {ir_sh[3:0], TDI};
        TAP_UPD_IR:   ir_out <= ir_sh;
        TAP_CAP_DR:   dr_sh  <= dr;
        TAP_SHIFT_DR: dr_sh  <= {dr_sh[6:0], TDI};
        TAP_UPD_DR:   dr     <= dr_sh;
        default: ;
      endcase
    end
  end

  assign TDO = (tap_st == TAP_SHIFT_IR) ? ir_sh[4] :
               (tap_st == TAP_SHIFT_DR) ? dr_sh[7] : 1'b0;

  // ---------------- helpers -----------------------------------------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void exp_trace(input logic is_ir, input int n,
                                    output logic [63:0] t, output int tn);
    t  = '0;
    tn = 0;
    if (n == 0) begin
      tn = 1;
      return;
    end
    t = {t[62:0], 1'b1}; tn++;
    if (is_ir) begin t = {t[62:0], 1'b1}; tn++; end
    t = {t[62:0], 1'b0}; tn++;
    t = {t[62:0], 1'b0}; tn++;
    for (int b = 0; b < n; b++) begin
      t = {t[62:0], (b == n - 1)};
      tn++;
    end
    t = {t[62:0], 1'b1}; tn++;
    t = {t[62:0], 1'b0}; tn++;
  endfunction

  // Called just after a negedge with cmd_ready high; returns at the negedge
  // where rsp_valid is seen, so a second call there is back-to-back.
  task automatic do_scan(input logic is_ir, input logic [5:0] len, input logic [31:0] data,
                         input logic hold, output logic [31:0] rsp, output int lat,
                         output logic [63:0] tr, output logic busy_bad);
    busy_bad  = 1'b0;
    tr        = '0;
    lat       = 0;
    rsp       = '0;
    cmd_is_ir = is_ir;
    cmd_len   = len;
    cmd_data  = data;
    cmd_valid = 1'b1;
    @(posedge TCK);
    for (int k = 0; k < 100; k++) begin
      @(negedge TCK);
      cmd_valid = hold;
      tr = {tr[62:0], TMS};
      if (rsp_valid) begin
        lat = k + 1;
        rsp = rsp_data;
        break;
      end
      if (cmd_ready) busy_bad = 1'b1;
    end
    cmd_valid = 1'b0;
  endtask

  typedef struct {
    logic        is_ir;
    logic [5:0]  len;
    logic [31:0] data;
    logic        hold;
    logic [31:0] exp_rsp;
    int          exp_lat;
    logic [7:0]  exp_tgt;
  } vec_t;

  localparam int NV = 5;

  initial begin
    vec_t        vecs [NV];
    logic [31:0] rsp, rsp2;
    int          lat, lat2, n, etn, rdy_edge;
    logic [63:0] tr, tr2, et;
    logic        busy_bad, saw_rsp;

    vecs[0] = '{1'b1, 6'd0,  32'h0000_0002, 1'b0, 32'h0000_001F, 11, 8'h02};
    vecs[1] = '{1'b0, 6'd8,  32'h0000_00A5, 1'b1, 32'h0000_003C, 13, 8'hA5};
    vecs[2] = '{1'b0, 6'd0,  32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 1,  8'hA5};
    vecs[3] = '{1'b0, 6'd40, 32'h1234_5678, 1'b0, 32'hA512_3456, 37, 8'h78};
    vecs[4] = '{1'b0, 6'd4,  32'hFFFF_FFF9, 1'b1, 32'h0000_0007, 9,  8'h89};

    TRST_N    = 1'b0;
    cmd_valid = 1'b0;
    cmd_is_ir = 1'b0;
    cmd_len   = '0;
    cmd_data  = '0;

    // reset values and release
    repeat (3) @(negedge TCK);
    check("rst_tms", TMS, 1'b1);
    check("rst_tdi", TDI, 1'b0);
    check("rst_ready", cmd_ready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data", rsp_data, 32'h0);
    TRST_N   = 1'b1;
    rdy_edge = 0;
    tr       = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge TCK);
      tr = {tr[62:0], TMS};
      if (cmd_ready) begin
        rdy_edge = k;
        break;
      end
    end
    check("release_ready_edge", rdy_edge, c_RDY_EDGE);
    check("release_tms_trace", tr, c_RST_TMS);

    // table-driven scans
    for (int i = 0; i < NV; i++) begin
      check($sformatf("v%0d_ready", i), cmd_ready, 1'b1);
      do_scan(vecs[i].is_ir, vecs[i].len, vecs[i].data, vecs[i].hold, rsp, lat, tr, busy_bad);
      n = vecs[i].is_ir ? 5 : ((vecs[i].len > 6'd32) ? 32 : int'(vecs[i].len));
      exp_trace(vecs[i].is_ir, n, et, etn);
      check($sformatf("v%0d_rsp", i), rsp, vecs[i].exp_rsp);
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_tms_trace", i), tr, et);
      if (vecs[i].hold) check($sformatf("v%0d_ready_busy", i), busy_bad, 1'b0);
      repeat (2) @(negedge TCK);
      check($sformatf("v%0d_rsp_stable", i), rsp_data, vecs[i].exp_rsp);
      if (vecs[i].is_ir) check($sformatf("v%0d_ir_out", i), {3'b000, ir_out}, vecs[i].exp_tgt);
      else               check($sformatf("v%0d_dr", i), dr, vecs[i].exp_tgt);
    end

    // back-to-back: IR bypass then DR len 1
    do_scan(1'b1, 6'd7, 32'h0000_001F, 1'b0, rsp, lat, tr, busy_bad);
    check("b2b_valid_ready", {rsp_valid, cmd_ready}, 2'b11);
    do_scan(1'b0, 6'd1, 32'h0000_0001, 1'b0, rsp2, lat2, tr2, busy_bad);
    check("b2b_tms_trace", {tr[10:0], tr2[5:0]}, 17'b11000000110100110);
    check("b2b_lat1", lat, 11);
    check("b2b_lat2", lat2, 6);
    check("b2b_rsp1", rsp, 32'h1F);
    check("b2b_rsp2", rsp2, 32'h1);
    repeat (2) @(negedge TCK);
    check("b2b_ir_out", ir_out, 5'b11111);
    check("b2b_dr", dr, 8'h13);

    // abort during the third DR shift bit, with cmd_valid held while busy
    cmd_is_ir = 1'b0;
    cmd_len   = 6'd8;
    cmd_data  = 32'h0000_00FF;
    cmd_valid = 1'b1;
    @(posedge TCK);
    saw_rsp = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      @(negedge TCK);
      if (rsp_valid) saw_rsp = 1'b1;
    end
    check("abort_tdi_before", TDI, 1'b1);
    #2 TRST_N = 1'b0;
    #1;
    check("abort_tms", TMS, 1'b1);
    check("abort_tdi", TDI, 1'b0);
    check("abort_ready", cmd_ready, 1'b0);
    check("abort_rsp_valid", rsp_valid, 1'b0);
    cmd_valid = 1'b0;
    repeat (2) begin
      @(negedge TCK);
      if (rsp_valid) saw_rsp = 1'b1;
    end
    TRST_N   = 1'b1;
    rdy_edge = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge TCK);
      if (rsp_valid) saw_rsp = 1'b1;
      if (cmd_ready) begin
        rdy_edge = k;
        break;
      end
    end
    check("abort_no_rsp", saw_rsp, 1'b0);
    check("abort_ready_edge", rdy_edge, c_RDY_EDGE);
    do_scan(1'b0, 6'd8, 32'h0000_005A, 1'b0, rsp, lat, tr, busy_bad);
    check("post_abort_rsp", rsp, 32'h3C);
    check("post_abort_lat", lat, 13);
    repeat (2) @(negedge TCK);
    check("post_abort_dr", dr, 8'h5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
